// File: rtl/shift_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer_pkg
//  Description : Shared encodings and helpers for the iterative ARM
//                shifter-operand unit: shift-op codes, FSM state codes,
//                step limits and the amount-to-step-count mapping.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_sequencer_pkg;

    // Shift operation encodings (match the instruction's shift-type field)
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Sequencer FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // Longest logical shift: 32 steps empty the register, one more clears carry
    localparam logic [7:0] MAX_STEPS     = 8'd33;
    // Arithmetic shift saturates at 32: result and carry are then all sign
    localparam logic [7:0] ASR_MAX_STEPS = 8'd32;
    // A rotate by a multiple of 32 still takes a full revolution so that
    // carry ends up as bit 31
    localparam logic [7:0] ROR_FULL      = 8'd32;

    // Number of single-bit steps for effective op/amount. Clamping happens
    // here in 8 bits so the narrower step counter never sees a wrapped value.
    function automatic logic [7:0] step_count(input logic [1:0] op,
                                              input logic [7:0] amt);
        logic [7:0] n;
        n = amt;
        if (amt == 8'd0) begin
            n = 8'd0;
        end else begin
            case (op)
                SH_LSL, SH_LSR: n = (amt > MAX_STEPS) ? MAX_STEPS : amt;
                SH_ASR:         n = (amt > ASR_MAX_STEPS) ? ASR_MAX_STEPS : amt;
                SH_ROR:         n = (amt[4:0] == 5'd0) ? ROR_FULL : {3'b000, amt[4:0]};
                default:        n = amt;
            endcase
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer_if
//  Description : Request/response bundle for shift_sequencer.
//                Request side : in_valid/in_ready, op, imm_mode, rot_imm,
//                               amount, operand, carry_in
//                Response side: out_valid/out_ready, result, carry_out
//                Status       : busy
//                master = issuing/consuming logic, slave = the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface shift_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             imm_mode;
    logic [3:0]       rot_imm;
    logic [7:0]       amount;
    logic [WIDTH-1:0] operand;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             busy;

    modport master (
        output in_valid, op, imm_mode, rot_imm, amount, operand, carry_in,
        output out_ready,
        input  in_ready, out_valid, result, carry_out, busy
    );

    modport slave (
        input  in_valid, op, imm_mode, rot_imm, amount, operand, carry_in,
        input  out_ready,
        output in_ready, out_valid, result, carry_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/shift_sequencer_shift_step.sv
`default_nettype none
// ============================================================================
//  Module      : shift_step
//  Description : Combinational single-bit shift step.
//                op      : shift type (LSL/LSR/ASR/ROR)
//                reg_in  : current shift register value
//                sign    : fill bit for ASR (sign of the original operand)
//                reg_out : value after one step
//                carry   : bit shifted out in this step
//  Revision    : 1.0  initial release
// ============================================================================
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic [1:0]       op,
    input  wire logic [WIDTH-1:0] reg_in,
    input  wire logic             sign,
    output logic      [WIDTH-1:0] reg_out,
    output logic                  carry
);

    always_comb begin
        reg_out = reg_in;
        carry   = 1'b0;
        case (op)
            SH_LSL: begin
                reg_out = {reg_in[WIDTH-2:0], 1'b0};
                carry   = reg_in[WIDTH-1];
            end
            SH_LSR: begin
                reg_out = {1'b0, reg_in[WIDTH-1:1]};
                carry   = reg_in[0];
            end
            SH_ASR: begin
                reg_out = {sign, reg_in[WIDTH-1:1]};
                carry   = reg_in[0];
            end
            SH_ROR: begin
                reg_out = {reg_in[0], reg_in[WIDTH-1:1]};
                carry   = reg_in[0];
            end
            default: begin
                reg_out = reg_in;
                carry   = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer
//  Description : Iterative ARM shifter-operand unit, one bit per clock.
//                Performs LSL/LSR/ASR/ROR by a register amount, or the
//                immediate form (8-bit value ROR by 2*rot_imm), producing
//                result and shifter carry-out behind valid/ready handshakes.
//                clk   : rising-edge clock
//                reset : synchronous, active-high
//                bus   : shift_sequencer_if.slave (request, response, busy)
//  Revision    : 1.0  initial release
// ============================================================================
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  wire logic          clk,
    input  wire logic          reset,
    shift_sequencer_if.slave   bus
);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_shift;
    logic             r_carry;
    logic             r_sign;
    logic [1:0]       r_op;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;
    logic             w_accept;
    logic             w_last_step;

    logic [WIDTH-1:0] w_eff_operand;
    logic [1:0]       w_eff_op;
    logic [7:0]       w_eff_amount;
    logic [7:0]       w_steps8;
    logic [CNT_W-1:0] w_steps;

    logic [WIDTH-1:0] w_step_reg;
    logic             w_step_carry;

    // Immediate form is an 8-bit value rotated right by twice the field
    assign w_eff_operand = bus.imm_mode ? {{(WIDTH-8){1'b0}}, bus.operand[7:0]}
                                        : bus.operand;
    assign w_eff_op      = bus.imm_mode ? SH_ROR : bus.op;
    assign w_eff_amount  = bus.imm_mode ? {3'b000, bus.rot_imm, 1'b0} : bus.amount;
    assign w_steps8      = step_count(w_eff_op, w_eff_amount);
    assign w_steps       = CNT_W'(w_steps8);

    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_last_step = (r_count == {{(CNT_W-1){1'b0}}, 1'b1});

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .op      (r_op),
        .reg_in  (r_shift),
        .sign    (r_sign),
        .reg_out (w_step_reg),
        .carry   (w_step_carry)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // Zero-step requests already hold their answer after load
                    w_next_state = (w_steps == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last_step) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE:  w_in_ready  = 1'b1;
            ST_SHIFT: w_busy      = 1'b1;
            ST_DONE: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
                w_busy      = 1'b0;
            end
        endcase
    end

    // ---------------- Datapath: load on accept, step while shifting -------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_carry <= 1'b0;
            r_sign  <= 1'b0;
            r_op    <= SH_LSL;
            r_count <= '0;
        end else if (w_accept) begin
            r_shift <= w_eff_operand;
            r_carry <= bus.carry_in;
            r_sign  <= w_eff_operand[WIDTH-1];
            r_op    <= w_eff_op;
            r_count <= w_steps;
        end else if (r_state == ST_SHIFT) begin
            r_shift <= w_step_reg;
            r_carry <= w_step_carry;
            r_count <= r_count - 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.result    = r_shift;
    assign bus.carry_out = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_sequencer
//  Description : Self-checking bench for shift_sequencer: directed vectors,
//                randomized requests against an arithmetic reference model,
//                output backpressure and mid-shift reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    shift_sequencer_if #(.WIDTH(32)) bus ();

    shift_sequencer #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: whole-word arithmetic shifts on widened values.
    function automatic void model(input logic [1:0] op_i, input logic imm,
                                  input logic [3:0] rot, input logic [7:0] amt,
                                  input logic [31:0] x_in, input logic cin,
                                  output logic [31:0] res, output logic c,
                                  output int n);
        logic [31:0] x;
        logic [63:0] p;
        logic [1:0]  o;
        int          a;
        int          r;
        x = imm ? {24'h0, x_in[7:0]} : x_in;
        a = imm ? int'(rot) * 2 : int'(amt);
        o = imm ? 2'd3 : op_i;
        res = x; c = cin; n = 0;
        if (a != 0) begin
            case (o)
                2'd0: begin
                    p = {32'h0, x} << a;
                    res = p[31:0]; c = p[32]; n = (a > 33) ? 33 : a;
                end
                2'd1: begin
                    p = {x, 32'h0} >> a;
                    res = p[63:32]; c = p[31]; n = (a > 33) ? 33 : a;
                end
                2'd2: begin
                    p = $signed({x, 32'h0}) >>> a;
                    res = p[63:32]; c = p[31]; n = (a > 32) ? 32 : a;
                end
                default: begin
                    r = a % 32;
                    if (r == 0) begin
                        res = x; c = x[31]; n = 32;
                    end else begin
                        res = (x >> r) | (x << (32 - r)); c = res[31]; n = r;
                    end
                end
            endcase
        end
    endfunction

    // One full transaction: issue, wait for result, hold off for `stall`
    // cycles, then complete the output handshake.
    task automatic run(input string tag, input logic [1:0] op, input logic imm,
                       input logic [3:0] rot, input logic [7:0] amt,
                       input logic [31:0] opd, input logic cin,
                       input logic [31:0] e_res, input logic e_c,
                       input int e_lat, input int stall);
        int lat;
        logic [31:0] held;
        @(negedge clk);
        chk({tag, ":in_ready_idle"}, {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1; bus.op = op; bus.imm_mode = imm; bus.rot_imm = rot;
        bus.amount = amt; bus.operand = opd; bus.carry_in = cin;
        @(negedge clk);
        // Scramble request fields: the DUT must work from its latched copy
        bus.in_valid = 1'b0; bus.op = 2'($urandom); bus.imm_mode = 1'($urandom);
        bus.rot_imm = 4'($urandom); bus.amount = 8'($urandom);
        bus.operand = $urandom; bus.carry_in = 1'($urandom);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ":latency"}, 32'(lat), 32'(e_lat + 0));
        chk({tag, ":result"}, bus.result, e_res);
        chk({tag, ":carry"}, {31'b0, bus.carry_out}, {31'b0, e_c});
        held = bus.result;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, ":stall_valid"}, {31'b0, bus.out_valid}, 32'd1);
            chk({tag, ":stall_result"}, bus.result, held);
            chk({tag, ":stall_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, ":valid_drop"}, {31'b0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] e_res;
        logic        e_c;
        int          e_n;
        logic [1:0]  r_op;
        logic        r_imm;
        logic [3:0]  r_rot;
        logic [7:0]  r_amt;
        logic [31:0] r_opd;
        logic        r_cin;
        int          spurious;

        n_total = 0; n_pass = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.op = 2'd0; bus.imm_mode = 1'b0; bus.rot_imm = 4'd0;
        bus.amount = 8'd0; bus.operand = 32'd0; bus.carry_in = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_carry", {31'b0, bus.carry_out}, 32'd0);
        reset = 1'b0;

        // Directed vectors
        run("lsl1",   SH_LSL, 1'b0, 4'd0,  8'd1,  32'h80000001, 1'b0, 32'h00000002, 1'b1, 2,  0);
        run("lsr32",  SH_LSR, 1'b0, 4'd0,  8'd32, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 33, 0);
        run("lsr40",  SH_LSR, 1'b0, 4'd0,  8'd40, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 34, 0);
        run("asr40",  SH_ASR, 1'b0, 4'd0,  8'd40, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1, 33, 0);
        run("asr4",   SH_ASR, 1'b0, 4'd0,  8'd4,  32'h7FFFFFF0, 1'b1, 32'h07FFFFFF, 1'b0, 5,  0);
        run("imm4",   SH_LSL, 1'b1, 4'd4,  8'd77, 32'hABCDEF44, 1'b1, 32'h44000000, 1'b0, 9,  0);
        run("imm15",  SH_LSR, 1'b1, 4'd15, 8'd3,  32'h12345644, 1'b0, 32'h00000110, 1'b0, 31, 0);
        run("imm0",   SH_ASR, 1'b1, 4'd0,  8'd9,  32'hFFFFFF44, 1'b1, 32'h00000044, 1'b1, 1,  0);
        run("ror32",  SH_ROR, 1'b0, 4'd0,  8'd32, 32'h80000001, 1'b0, 32'h80000001, 1'b1, 33, 0);
        run("ror36",  SH_ROR, 1'b0, 4'd0,  8'd36, 32'h0000000F, 1'b0, 32'hF0000000, 1'b1, 5,  0);
        run("amt0",   SH_LSR, 1'b0, 4'd0,  8'd0,  32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 1,  0);
        run("bp5",    SH_LSL, 1'b0, 4'd0,  8'd3,  32'h00000001, 1'b0, 32'h00000008, 1'b0, 4,  5);

        // Randomized requests against the reference model
        for (int k = 0; k < 25; k++) begin
            r_op  = 2'($urandom);
            r_imm = ($urandom_range(0, 4) == 0);
            r_rot = 4'($urandom);
            r_amt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
            r_opd = $urandom;
            r_cin = 1'($urandom);
            model(r_op, r_imm, r_rot, r_amt, r_opd, r_cin, e_res, e_c, e_n);
            run($sformatf("rnd%0d", k), r_op, r_imm, r_rot, r_amt, r_opd, r_cin,
                e_res, e_c, e_n + 1, $urandom_range(0, 2));
        end

        // Reset in the middle of a long shift
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = SH_LSR; bus.imm_mode = 1'b0;
        bus.amount = 8'd40; bus.operand = 32'hFFFFFFFF; bus.carry_in = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", {31'b0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("mrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("mrst_result", bus.result, 32'd0);
        chk("mrst_carry", {31'b0, bus.carry_out}, 32'd0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) spurious++;
        end
        bus.out_ready = 1'b0;
        chk("mrst_no_valid", 32'(spurious), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
